// File: rtl/sysid_plus.sv
// sysid_plus: Avalon-MM system-identification slave.
// Returns build ID, build timestamp, capability word and user status words,
// and provides a byte-writable scratch register.
// Optional feature macro: SYSID_PLUS_UPTIME_EN builds the 64-bit uptime
// counter (word 3) and its coherent high-word shadow (word 4); without it
// both words read 0 and capability bit 0 is clear.
module sysid_plus #(
  parameter logic [31:0] SYSTEM_ID      = 32'hA5A5_0002,
  parameter logic [31:0] TIMESTAMP      = 32'h5560_0000,
  parameter logic [31:0] SCRATCH_INIT   = 32'h0000_0000,
  parameter int unsigned NUM_USER_WORDS = 4,
  parameter int unsigned ADDR_W         = 4,
  localparam int unsigned UW_N          = (NUM_USER_WORDS > 0) ? NUM_USER_WORDS : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic [3:0]           byteenable,
  input  logic [32*UW_N-1:0]   user_words,
  output logic [31:0]          readdata,
  output logic                 readdatavalid
);

  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TS      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CAP     = ADDR_W'(5);
  localparam int unsigned       USER_BASE = 6;

`ifdef SYSID_PLUS_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPABILITY = {8'h02, 8'(NUM_USER_WORDS), 15'b0, UPTIME_PRESENT};

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] readdata_q, readdata_d;
  logic        readdatavalid_q, readdatavalid_d;
  logic [31:0] rd_word;
  logic        wr_scratch;

`ifdef SYSID_PLUS_UPTIME_EN
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] shadow_q, shadow_d;

  // Free-running uptime; a low-word read captures the high word for a coherent pair
  always_comb begin
    uptime_d = uptime_q + 64'd1;
    shadow_d = shadow_q;
    if (read && (address == A_UP_LO)) begin
      shadow_d = uptime_q[63:32];
    end
  end

  // Uptime counter and shadow registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime_q <= '0;
      shadow_q <= '0;
    end else begin
      uptime_q <= uptime_d;
      shadow_q <= shadow_d;
    end
  end
`endif

  // Read data multiplexer over the word map; unmapped words read 0
  always_comb begin
    rd_word = '0;
    case (address)
      A_ID:      rd_word = SYSTEM_ID;
      A_TS:      rd_word = TIMESTAMP;
      A_SCRATCH: rd_word = scratch_q;
`ifdef SYSID_PLUS_UPTIME_EN
      A_UP_LO:   rd_word = uptime_q[31:0];
      A_UP_HI:   rd_word = shadow_q;
`endif
      A_CAP:     rd_word = CAPABILITY;
      default: begin
        for (int unsigned k = 0; k < NUM_USER_WORDS; k++) begin
          if (32'(address) == (k + USER_BASE)) begin
            rd_word = user_words[32*k +: 32];
          end
        end
      end
    endcase
  end

  // Scratch write with per-lane byte enables; a simultaneous read drops the write
  always_comb begin
    wr_scratch = write && !read && (address == A_SCRATCH);
    scratch_d  = scratch_q;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wr_scratch && byteenable[b]) begin
        scratch_d[8*b +: 8] = writedata[8*b +: 8];
      end
    end
  end

  // Registered read response: data holds until the next read completes
  always_comb begin
    readdatavalid_d = read;
    readdata_d      = read ? rd_word : readdata_q;
  end

  // Scratch and read-response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch_q       <= SCRATCH_INIT;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      scratch_q       <= scratch_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_sysid_plus.sv
// Testbench for sysid_plus: directed and random register accesses checked
// against a word-map model of the slave.
module tb_sysid_plus;

  localparam logic [31:0] SYSTEM_ID    = 32'hA5A5_0002;
  localparam logic [31:0] TIMESTAMP    = 32'h5560_0000;
  localparam logic [31:0] SCRATCH_INIT = 32'h0BAD_F00D;

`ifdef SYSID_PLUS_UPTIME_EN
  localparam bit UP_EN = 1'b1;
`else
  localparam bit UP_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   address = '0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  writedata = '0;
  logic [3:0]   byteenable = '0;
  logic [127:0] user_words;
  logic [31:0]  readdata;
  logic         readdatavalid;

  logic [31:0] uw [4];
  assign user_words = {uw[3], uw[2], uw[1], uw[0]};

  sysid_plus #(
    .SYSTEM_ID      (SYSTEM_ID),
    .TIMESTAMP      (TIMESTAMP),
    .SCRATCH_INIT   (SCRATCH_INIT),
    .NUM_USER_WORDS (4),
    .ADDR_W         (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .user_words    (user_words),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  // Model state
  int unsigned     n_checks = 0;
  int unsigned     n_fail   = 0;
  logic [31:0]     scratch_m;
  logic [31:0]     shadow_m;
  logic [31:0]     last_rd;
  longint unsigned edge_cnt  = 0;
  longint unsigned base_up   = 0;
  longint unsigned base_edge = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Uptime value the DUT holds at the coming rising edge
  function automatic longint unsigned up_now();
    return base_up + (edge_cnt - base_edge);
  endfunction

  function automatic logic [31:0] exp_word(int unsigned a);
    longint unsigned up;
    up = up_now();
    case (a)
      0: return SYSTEM_ID;
      1: return TIMESTAMP;
      2: return scratch_m;
      3: return UP_EN ? up[31:0] : 32'h0;
      4: return UP_EN ? shadow_m : 32'h0;
      5: return {8'h02, 8'd4, 15'd0, UP_EN};
      6, 7, 8, 9: return uw[a-6];
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle, starting and ending at a falling edge
  task automatic cycle(input bit rd, input bit wr, input int unsigned a,
                       input logic [31:0] wd, input logic [3:0] be, input string tag);
    logic [31:0] e;
    longint unsigned up;
    read       = rd;
    write      = wr;
    address    = a[3:0];
    writedata  = wd;
    byteenable = be;
    up = up_now();
    e  = rd ? exp_word(a) : last_rd;
    if (rd && a == 3 && UP_EN) shadow_m = up[63:32];
    if (wr && !rd && a == 2) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) scratch_m[8*b +: 8] = wd[8*b +: 8];
    end
    @(posedge clock);
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
    chk({tag, "_valid"}, {31'b0, readdatavalid}, {31'b0, rd});
    chk({tag, "_data"}, readdata, e);
    last_rd = e;
  endtask

  task automatic model_reset();
    scratch_m = SCRATCH_INIT;
    shadow_m  = '0;
    last_rd   = '0;
    base_up   = 0;
    base_edge = edge_cnt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_valid", {31'b0, readdatavalid}, 32'h0);
    chk("rst_data", readdata, 32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    uw[0] = '0; uw[1] = '0; uw[2] = '0; uw[3] = '0;
    @(negedge clock);
    do_reset();

    // Identity words back-to-back
    cycle(1, 0, 0, '0, '0, "id");
    cycle(1, 0, 1, '0, '0, "ts");
    cycle(1, 0, 5, '0, '0, "cap");
    chk("cap_const", last_rd, UP_EN ? 32'h0204_0001 : 32'h0204_0000);
    cycle(0, 0, 0, '0, '0, "hold");

    // Scratch reset value and byte-lane writes
    cycle(1, 0, 2, '0, '0, "scr_init");
    cycle(0, 1, 2, 32'h1234_5678, 4'b1111, "wr_full");
    cycle(0, 1, 2, 32'hFFFF_FFFF, 4'b0101, "wr_lanes");
    cycle(1, 0, 2, '0, '0, "scr_lanes");
    chk("scr_lanes_const", last_rd, 32'h12FF_56FF);
    cycle(0, 1, 2, 32'h0, 4'b0000, "wr_be0");
    cycle(1, 0, 2, '0, '0, "scr_be0");
    cycle(0, 1, 0, 32'hDEAD_BEEF, 4'b1111, "wr_ro");
    cycle(0, 1, 13, 32'hDEAD_BEEF, 4'b1111, "wr_unmapped");
    cycle(1, 0, 0, '0, '0, "id_after_wr");
    cycle(1, 0, 2, '0, '0, "scr_after_ro");

    // Simultaneous read and write: read wins, write dropped
    cycle(1, 1, 2, 32'h0, 4'b1111, "rdwr");
    cycle(1, 0, 2, '0, '0, "scr_after_rdwr");
    chk("scr_after_rdwr_const", last_rd, 32'h12FF_56FF);

    // User words and unmapped tail
    uw[0] = 32'hA; uw[1] = 32'hB; uw[2] = 32'hC; uw[3] = 32'hD;
    for (int unsigned a = 6; a < 16; a++) cycle(1, 0, a, '0, '0, "user");

    // Uptime / shadow words
    cycle(1, 0, 3, '0, '0, "up_lo");
    repeat (3) cycle(0, 0, 0, '0, '0, "idle");
    cycle(1, 0, 4, '0, '0, "up_hi");

`ifdef SYSID_PLUS_UPTIME_EN
    force dut.uptime_q = 64'h0000_0001_FFFF_FFFE;
    #1;
    release dut.uptime_q;
    base_up   = 64'h0000_0001_FFFF_FFFE;
    base_edge = edge_cnt;
    cycle(1, 0, 3, '0, '0, "force_lo");
    chk("force_lo_const", last_rd, 32'hFFFF_FFFE);
    repeat (4) cycle(0, 0, 0, '0, '0, "idle");
    cycle(1, 0, 4, '0, '0, "force_hi");
    chk("force_hi_const", last_rd, 32'h0000_0001);
    repeat (3) cycle(0, 0, 0, '0, '0, "idle");
    cycle(1, 0, 4, '0, '0, "force_hi_again");
    cycle(1, 0, 3, '0, '0, "force_lo_wrap");
`endif

    // Random traffic
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) uw[$urandom_range(0, 3)] = $urandom;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 32'd2 : $urandom_range(0, 15),
            $urandom, 4'($urandom_range(0, 15)), "rand");
    end

    // Reset right after a read edge kills the pulse and clears readdata
    read    = 1'b1;
    address = 4'd0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    read = 1'b0;
    chk("midrst_valid", {31'b0, readdatavalid}, 32'h0);
    chk("midrst_data", readdata, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    cycle(1, 0, 2, '0, '0, "scr_after_rst");
    cycle(1, 0, 3, '0, '0, "up_after_rst");
    cycle(1, 0, 4, '0, '0, "hi_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
